// File: rtl/decryption_if.sv
// Handshake and data bundle for the PRESENT-80 decryptor.
// The controller drives it as master and the core sits on the slave side.
interface decryption_if;
  logic [63:0] cipher_text;
  logic [79:0] master_key;
  logic        dec_start;
  logic [63:0] plain_text;
  logic        dec_done;
  logic        dec_busy;

  modport master (
    output cipher_text,
    output master_key,
    output dec_start,
    input  plain_text,
    input  dec_done,
    input  dec_busy
  );

  modport slave (
    input  cipher_text,
    input  master_key,
    input  dec_start,
    output plain_text,
    output dec_done,
    output dec_busy
  );
endinterface

// File: rtl/decryption.sv
// PRESENT-80 block decryptor: forward key schedule to K32,
// then 31 inverse rounds rolling the key register backwards.
module decryption (
  input logic         clk,
  input logic         reset,
  decryption_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    ROUND,
    DONE
  } st_e;

  localparam logic [63:0] SB  = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBI = 64'hA970364BD21C8FE5;

  st_e         st_q, st_d;
  logic [4:0]  rc_q, rc_d;
  logic [79:0] key_q, key_d;
  logic [63:0] state_q, state_d;
  logic [63:0] pt_q, pt_d;
  logic        done_q, done_d;

  logic [63:0] rx, px, sx;
  logic [79:0] kf_rot, kf;
  logic [79:0] ki_x, ki_s, ki;

  // Inverse round: add key, inverse bit permutation, inverse S-box
  assign rx = state_q ^ key_q[79:16];

  for (genvar i = 0; i < 63; i++) begin : g_invp
    assign px[(4*i) % 63] = rx[i];
  end
  assign px[63] = rx[63];

  for (genvar j = 0; j < 16; j++) begin : g_invs
    assign sx[4*j +: 4] = SBI[{px[4*j +: 4], 2'b00} +: 4];
  end

  assign kf_rot = {key_q[18:0], key_q[79:19]};
  assign kf = {SB[{kf_rot[79:76], 2'b00} +: 4],
               kf_rot[75:20],
               kf_rot[19:15] ^ rc_q,
               kf_rot[14:0]};

  assign ki_x = {key_q[79:20], key_q[19:15] ^ rc_q, key_q[14:0]};
  assign ki_s = {SBI[{ki_x[79:76], 2'b00} +: 4], ki_x[75:0]};
  assign ki   = {ki_s[60:0], ki_s[79:61]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (bus.dec_start) st_d = KEYEXP;
      KEYEXP:  if (rc_q == 5'd31) st_d = ROUND;
      ROUND:   if (rc_q == 5'd1) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.dec_start) begin
          state_d = bus.cipher_text;
          key_d   = bus.master_key;
          rc_d    = 5'd1;
        end
      end
      KEYEXP: begin
        key_d = kf;
        if (rc_q != 5'd31) rc_d = rc_q + 5'd1;
      end
      ROUND: begin
        state_d = sx;
        key_d   = ki;
        rc_d    = rc_q - 5'd1;
      end
      DONE: begin
        pt_d   = rx;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  assign bus.plain_text = pt_q;
  assign bus.dec_done   = done_q;
  assign bus.dec_busy   = (st_q != IDLE);

endmodule

// File: tb/tb_decryption.sv
// Bench for the PRESENT-80 decryptor: known-answer vectors,
// handshake timing, reset abort and random loopback.
module tb_decryption;

  logic clk = 1'b0;
  logic reset = 1'b1;

  decryption_if bus ();

  decryption dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] rk [$];

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_keys(input logic [79:0] k);
    logic [79:0] r;
    r = k;
    rk.delete();
    for (int i = 1; i <= 32; i++) begin
      rk.push_back(r[79:16]);
      r = {r[18:0], r[79:19]};
      r[79:76] = SBOX[r[79:76]];
      r[19:15] = r[19:15] ^ 5'(i);
    end
  endtask

  function automatic logic [63:0] sub_layer(input logic [63:0] x);
    logic [63:0] r;
    logic [3:0] nib;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      nib = 4'((x >> (4*j)) & 64'hF);
      r = r | (64'(SBOX[nib]) << (4*j));
    end
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r = x & 64'h8000_0000_0000_0000;
    for (int i = 0; i < 63; i++)
      r = r | (((x >> i) & 64'd1) << ((16*i) % 63));
    return r;
  endfunction

  task automatic model_enc(input logic [63:0] p, input logic [79:0] k,
                           output logic [63:0] c);
    logic [63:0] s;
    gen_keys(k);
    s = p;
    for (int i = 0; i < 31; i++) begin
      s = s ^ rk[i];
      s = sub_layer(s);
      s = p_layer(s);
    end
    c = s ^ rk[31];
  endtask

  task automatic start_dec(input logic [63:0] ct, input logic [79:0] k);
    @(negedge clk);
    bus.cipher_text = ct;
    bus.master_key  = k;
    bus.dec_start   = 1'b1;
    @(posedge clk);
    #1;
    bus.dec_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.dec_done) break;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [63:0] p, c, p4, c4, p5, c5, p6, c6;
    logic [79:0] k, k4, k5, k6;

    bus.cipher_text = '0;
    bus.master_key  = '0;
    bus.dec_start   = 1'b0;
    #1 reset = 1'b0;
    #11;
    chk("rst_busy", 80'(bus.dec_busy), 80'd0);
    chk("rst_done", 80'(bus.dec_done), 80'd0);
    chk("rst_pt", 80'(bus.plain_text), 80'd0);
    @(negedge clk);
    reset = 1'b1;

    model_enc(64'h0, 80'h0, c);
    chk("model_kat", 80'(c), 80'h5579C1387B228445);

    start_dec(64'h5579C1387B228445, 80'h0);
    chk("busy_e0", 80'(bus.dec_busy), 80'd1);
    wait_done(lat);
    chk("lat_kat0", 80'(lat), 80'd63);
    chk("pt_kat0", 80'(bus.plain_text), 80'h0);
    chk("busy_e63", 80'(bus.dec_busy), 80'd0);
    @(posedge clk);
    #1;
    chk("done_e64", 80'(bus.dec_done), 80'd0);
    chk("hold_kat0", 80'(bus.plain_text), 80'h0);

    start_dec(64'hE72C46C0F5945049, {80{1'b1}});
    wait_done(lat);
    chk("pt_kat1", 80'(bus.plain_text), 80'h0);
    start_dec(64'h3333DCD3213210D2, {80{1'b1}});
    wait_done(lat);
    chk("pt_kat2", 80'(bus.plain_text), 80'hFFFFFFFFFFFFFFFF);

    start_dec(64'hA112FFC72F68417B, 80'h0);
    bus.cipher_text = {$urandom, $urandom};
    bus.master_key  = {$urandom, $urandom, 16'($urandom)};
    wait_done(lat);
    chk("lat_kat3", 80'(lat), 80'd63);
    chk("pt_kat3", 80'(bus.plain_text), 80'hFFFFFFFFFFFFFFFF);

    p4 = {$urandom, $urandom};
    k4 = {$urandom, $urandom, 16'($urandom)};
    model_enc(p4, k4, c4);
    start_dec(c4, k4);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.dec_start   = 1'b1;
    bus.cipher_text = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bus.dec_start = 1'b0;
    chk("busy_e10", 80'(bus.dec_busy), 80'd1);
    wait_done(lat);
    chk("lat_ignore", 80'(lat), 80'd53);
    chk("pt_ignore", 80'(bus.plain_text), 80'(p4));

    p5 = {$urandom, $urandom} | 64'h1;
    k5 = {$urandom, $urandom, 16'($urandom)};
    model_enc(p5, k5, c5);
    start_dec(c5, k5);
    chk("done_b2b", 80'(bus.dec_done), 80'd0);
    chk("busy_b2b", 80'(bus.dec_busy), 80'd1);
    wait_done(lat);
    chk("lat_b2b", 80'(lat), 80'd63);
    chk("pt_b2b", 80'(bus.plain_text), 80'(p5));

    p6 = {$urandom, $urandom};
    k6 = {$urandom, $urandom, 16'($urandom)};
    model_enc(p6, k6, c6);
    start_dec(c6, k6);
    repeat (39) begin
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 80'(bus.dec_busy), 80'd0);
    chk("abort_done", 80'(bus.dec_done), 80'd0);
    chk("abort_pt", 80'(bus.plain_text), 80'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.dec_done) ndone++;
    end
    chk("abort_nopulse", 80'(ndone), 80'd0);
    start_dec(c6, k6);
    wait_done(lat);
    chk("lat_fresh", 80'(lat), 80'd63);
    chk("pt_fresh", 80'(bus.plain_text), 80'(p6));

    for (int n = 0; n < 200; n++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, 16'($urandom)};
      model_enc(p, k, c);
      start_dec(c, k);
      wait_done(lat);
      chk("loopback", 80'(bus.plain_text), 80'(p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decryption.md
# decryption

PRESENT-80 block decryptor: the receive-side counterpart of the `encrytion` core, sharing its 64-bit block, 80-bit master key, and start/done handshake. It takes a 64-bit ciphertext and the same 80-bit master key used for encryption and returns the plaintext. The block first runs the forward key schedule to reach round key K32. It then applies 31 inverse rounds, one per clock, rolling the key register backwards. It sits beside the encryptor in the crypto datapath and is driven by the same controller.

## Interface
- No parameters; the algorithm is fixed at PRESENT-80 (31 rounds).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state clears while low.
- `cipher_text` in 64: ciphertext, sampled only on the accept edge.
- `master_key` in 80: master key (K1 source), sampled only on the accept edge.
- `dec_start` in 1: start request, level-sampled.
- `plain_text` out 64: result, registered, held until the next result.
- `dec_done` out 1: one-cycle completion pulse.
- `dec_busy` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, KEYEXP, ROUND, DONE. A 5-bit round counter `rc` and an 80-bit key register `key` step the key schedule; a 64-bit register `state` holds the data.
- IDLE with `dec_start`=1 (accept edge):
  - `state`<=`cipher_text`, `key`<=`master_key`, `rc`<=1.
  - Go to KEYEXP.
- KEYEXP, 31 cycles, rc=1..31. Apply the forward update:
  - Rotate the key left 61.
  - Replace key[79:76] with S(key[79:76]).
  - XOR rc into key[19:15].
  - At rc=31, go to ROUND with rc kept at 31. `key` now holds the K32 register.
- ROUND, 31 cycles, rc=31 down to 1:
  - `state`<=invS(invP(`state` ^ `key`[79:16])).
  - Inverse key update on `key`: XOR rc into key[19:15], replace key[79:76] with Sinv(key[79:76]), then rotate right 61.
  - At rc=1, go to DONE. `key` is back to the `master_key` value.
- DONE, 1 cycle: `plain_text`<=`state` ^ `key`[79:16] (applies K1), `dec_done`<=1, go to IDLE.
- Substitution tables:
  - S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
  - Both apply to all 16 nibbles of `state` and to nibble key[79:76] in the key schedule.
- invP: input bit i moves to position (4·i) mod 63 for i<63; bit 63 stays in place. This is the inverse of the encryptor's 16·i mod 63.
- `dec_start` is ignored while `dec_busy`=1. `cipher_text` and `master_key` may change freely after the accept edge.

## Timing
- Reset values: `plain_text`=0, `dec_done`=0, `dec_busy`=0, FSM=IDLE, `state`=0, `key`=0, `rc`=0.
- Edge numbering, with accept edge = E0:
  - E1..E31: KEYEXP.
  - E32..E62: ROUND.
  - E63: `plain_text` valid and `dec_done`=1.
  - E64: `dec_done`=0.
- Latency is 63 clocks from the accept edge to `dec_done`.
- `dec_busy` rises at E0 and falls at E63.
- A new start held high at E63 is not accepted at E63 (FSM is still in DONE). It is accepted at E64; back-to-back throughput is one block per 64 clocks.
- `dec_start` held high continuously restarts a new decryption at every IDLE edge with the current inputs.
- `reset` low at any point clears all registers immediately. A decryption in flight is abandoned with no `dec_done`, and `plain_text` returns to 0.
- `plain_text` holds its value after `dec_done` until the next DONE or reset.

## Test plan
- Key 0, ct 5579C1387B228445, start pulse -> `dec_done` exactly 63 clocks after the accept edge, `plain_text`=0000000000000000.
- Key FFFFFFFFFFFFFFFFFFFF, ct E72C46C0F5945049 -> `plain_text`=0; then ct 3333DCD3213210D2 with the same key -> `plain_text`=FFFFFFFFFFFFFFFF.
- Key 0, ct A112FFC72F68417B -> `plain_text`=FFFFFFFFFFFFFFFF. Change the key and ct inputs on the cycle after the accept edge -> result unchanged.
- Start pulsed again at E10 during a decryption -> ignored, `dec_busy` stays high, single `dec_done` at E63 with the correct result. Start at E64 -> accepted, second result 63 clocks later.
- `reset` low at E40 -> `dec_busy`/`dec_done`/`plain_text` go to 0 asynchronously and no pulse follows. After release, a fresh start decrypts correctly.
- Loopback: 200 random key/plaintext pairs through `encrytion` then `decryption` -> recovered text equals the original every time.
